alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, clocked successor to the combinational pipeline ALU. It adds a valid/ready handshake at input and output. Single-cycle ops (add, logic, shift, compare) complete in 1 cycle. Full-width RISC-V M-extension multiply/divide run on iterative shift-add / restoring-division datapaths. It sits in the EX stage; the pipeline stalls on in_ready/out_valid.

Parameters:
DATA_WIDTH, 32, operand/result width; any even value >= 8.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE; accept on in_valid && in_ready.
alu_op  input  4  opcode, captured at accept.
operand1  input  DATA_WIDTH  rs1 value, captured at accept.
operand2  input  DATA_WIDTH  rs2 value, captured at accept.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
result  output  DATA_WIDTH  registered result.
zero_flag  output  1  registered (result == 0).
div_by_zero  output  1  registered; high when a DIV/DIVU/REM/REMU had operand2 == 0.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA. Shift amount is operand2[$clog2(DATA_WIDTH)-1:0].
  - 1000 MUL (low W bits), 1001 MULH (signed x signed, high W), 1010 MULHU (unsigned, high W).
  - 1011 DIV, 1100 DIVU, 1101 REM, 1110 REMU.
  - 1111 SLT (signed, result 0 or 1).
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE on accept of a single-cycle op or a special-case divide.
  - IDLE -> MUL / DIV on accept of a mul/div op; counter loaded with DATA_WIDTH.
  - MUL / DIV: one iteration per cycle; counter decrements; at count 1 -> DONE with final sign correction applied.
  - DONE: out_valid=1; result, zero_flag and div_by_zero held stable. On out_ready -> IDLE.
- Latency (accept edge = cycle 0):
  - Single-cycle ops: out_valid at cycle 1.
  - MUL*/DIV*/REM*: out_valid at cycle DATA_WIDTH+1.
  - Special-case divides: out_valid at cycle 1.
- Throughput: in_ready is low in MUL, DIV and DONE. Back-to-back ops are separated by at least one IDLE cycle.
- Input stability: inputs are ignored outside an accept. Operands are latched, so changes while busy have no effect.
- Multiply: on magnitudes (shift-add, 2W-bit accumulator). Product is negated when MULH operand signs differ; MUL uses the low word (sign-independent).
- Divide: restoring, on magnitudes. Signed quotient is negative if signs differ; remainder takes the dividend's sign.
- Special cases:
  - Divide by zero: quotient = all ones; remainder = operand1; div_by_zero = 1.
  - Signed overflow (most-negative / -1): quotient = operand1; remainder = 0; div_by_zero = 0.
- div_by_zero: 0 for all non-divide ops.
- Reset (any state, including mid-iteration):
  - Next cycle: state IDLE, in_ready=1, out_valid=0, result=0, zero_flag=0, div_by_zero=0.
  - The in-flight operation is discarded.
- in_valid while not ready: ignored. The requester must hold it; no queuing.

Optional Feature:
Macro ALU_MC_DIVIDER_EN.
- Defined: divider datapath, DIV state and opcodes 1011-1110 are implemented as above.
- Undefined:
  - No divider logic or DIV state is built.
  - Opcodes 1011-1110 complete in 1 cycle with result=0, zero_flag=1, div_by_zero=0.
  - All other behaviour is unchanged.

Test Plan:
1. ADD 0x7FFFFFFF, 0x00000001 (W=32) -> out_valid at cycle 1, result 0x80000000, zero_flag 0. Then SUB 5, 5 -> result 0, zero_flag 1.
2. MUL / MULH / MULHU with 0xFFFFFFFF, 0x00000002 -> results 0xFFFFFFFE / 0xFFFFFFFF / 0x00000001. out_valid at cycle 33 each; in_ready low throughout.
3. DIV -7 (0xFFFFFFF9), 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100, 7 -> 14. REMU 100, 7 -> 2. Each at cycle 33.
4. DIV 5, 0 -> result 0xFFFFFFFF, div_by_zero 1, cycle 1. REMU 5, 0 -> 5, div_by_zero 1. DIV 0x80000000, 0xFFFFFFFF -> 0x80000000, cycle 1; REM of the same operands -> 0.
5. Backpressure: complete any op with out_ready held low for 5 cycles. result must stay stable and in_ready low. Raise out_ready: IDLE next cycle, in_ready 1.
6. Assert rst at cycle 10 of a MULH. Next cycle: out_valid 0, result 0, in_ready 1. A new ADD 2, 3 then returns 5 at cycle 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes, iterative multiply and optional divide.
// Define ALU_MC_DIVIDER_EN to build the restoring divider (DIV/DIVU/REM/REMU).
module alu_multicycle #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero_flag,
    output logic                  div_by_zero
);
    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam int SH_WIDTH  = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100, OP_SLL = 4'b0101, OP_SRL = 4'b0110, OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000, OP_MULH = 4'b1001, OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011, OP_DIVU = 4'b1100, OP_REM = 4'b1101, OP_REMU = 4'b1110;
    localparam logic [3:0] OP_SLT = 4'b1111;

`ifdef ALU_MC_DIVIDER_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd3} state_t;
`endif

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    state_t               state;
    logic [3:0]           op_reg;
    logic [CNT_WIDTH-1:0] count;
    logic [2*W-1:0]       acc, mcand, acc_next, product;
    logic [W-1:0]         mplier, mul_out;
    logic                 neg_res;
    logic [W-1:0]         quick_res;
    logic                 quick_dbz, go_mul, go_div;
    logic [SH_WIDTH-1:0]  shamt;

    assign shamt = operand2[SH_WIDTH-1:0];

    // Result for everything that finishes on the accept edge, plus routing of iterative ops.
    always_comb begin
        quick_res = '0;
        quick_dbz = 1'b0;
        go_mul    = 1'b0;
        go_div    = 1'b0;
        case (alu_op)
            OP_ADD:  quick_res = operand1 + operand2;
            OP_SUB:  quick_res = operand1 - operand2;
            OP_AND:  quick_res = operand1 & operand2;
            OP_OR:   quick_res = operand1 | operand2;
            OP_XOR:  quick_res = operand1 ^ operand2;
            OP_SLL:  quick_res = operand1 << shamt;
            OP_SRL:  quick_res = operand1 >> shamt;
            OP_SRA:  quick_res = $signed(operand1) >>> shamt;
            OP_SLT:  quick_res = {{(W-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            OP_MUL, OP_MULH, OP_MULHU: go_mul = 1'b1;
`ifdef ALU_MC_DIVIDER_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (operand2 == '0) begin
                    quick_dbz = 1'b1;
                    quick_res = (alu_op == OP_DIV || alu_op == OP_DIVU) ? '1 : operand1;
                end else if ((alu_op == OP_DIV || alu_op == OP_REM) &&
                             operand1 == MOST_NEG && operand2 == '1) begin
                    quick_res = (alu_op == OP_DIV) ? operand1 : '0;
                end else begin
                    go_div = 1'b1;
                end
            end
`endif
            default: quick_res = '0;
        endcase
    end

    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
        product  = neg_res ? -acc_next : acc_next;
        mul_out  = (op_reg == OP_MUL) ? product[W-1:0] : product[2*W-1:W];
    end

`ifdef ALU_MC_DIVIDER_EN
    logic [W-1:0] div_rem, div_quo, divisor, div_diff, rem_next, quo_next, div_out;
    logic [W:0]   div_shift;
    logic         neg_rem, borrow;

    // One restoring step; the modular difference is exact whenever no borrow occurs.
    always_comb begin
        div_shift = {div_rem, div_quo[W-1]};
        borrow    = div_shift < {1'b0, divisor};
        div_diff  = div_shift[W-1:0] - divisor;
        rem_next  = borrow ? div_shift[W-1:0] : div_diff;
        quo_next  = {div_quo[W-2:0], ~borrow};
        if (op_reg == OP_DIV || op_reg == OP_DIVU)
            div_out = neg_res ? -quo_next : quo_next;
        else
            div_out = neg_rem ? -rem_next : rem_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            zero_flag   <= 1'b0;
            div_by_zero <= 1'b0;
            op_reg      <= '0;
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            neg_res     <= 1'b0;
`ifdef ALU_MC_DIVIDER_EN
            div_rem     <= '0;
            div_quo     <= '0;
            divisor     <= '0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_reg   <= alu_op;
                    in_ready <= 1'b0;
                    count    <= CNT_INIT;
                    if (go_mul) begin
                        state <= ST_MUL;
                        acc   <= '0;
                        if (alu_op == OP_MULH) begin
                            mcand   <= {{W{1'b0}}, mag(operand1)};
                            mplier  <= mag(operand2);
                            neg_res <= operand1[W-1] ^ operand2[W-1];
                        end else begin
                            mcand   <= {{W{1'b0}}, operand1};
                            mplier  <= operand2;
                            neg_res <= 1'b0;
                        end
`ifdef ALU_MC_DIVIDER_EN
                    end else if (go_div) begin
                        state   <= ST_DIV;
                        div_rem <= '0;
                        if (alu_op == OP_DIV || alu_op == OP_REM) begin
                            div_quo <= mag(operand1);
                            divisor <= mag(operand2);
                            neg_res <= operand1[W-1] ^ operand2[W-1];
                            neg_rem <= operand1[W-1];
                        end else begin
                            div_quo <= operand1;
                            divisor <= operand2;
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                        end
`endif
                    end else begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        result      <= quick_res;
                        zero_flag   <= (quick_res == '0);
                        div_by_zero <= quick_dbz;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[2*W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[W-1:1]};
                    count  <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        result      <= mul_out;
                        zero_flag   <= (mul_out == '0);
                        div_by_zero <= 1'b0;
                    end
                end
`ifdef ALU_MC_DIVIDER_EN
                ST_DIV: begin
                    div_rem <= rem_next;
                    div_quo <= quo_next;
                    count   <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        result      <= div_out;
                        zero_flag   <= (div_out == '0);
                        div_by_zero <= 1'b0;
                    end
                end
`endif
                ST_DONE: if (out_ready) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at DATA_WIDTH=32.
// Divide tests follow ALU_MC_DIVIDER_EN: full divider when defined, fixed zero result otherwise.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, zero_flag, div_by_zero;
    logic [3:0]  alu_op;
    logic [31:0] operand1, operand2, result;
    int          pass_count = 0;
    int          check_count = 0;

    alu_multicycle #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero_flag(zero_flag), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Handshake one op, scramble the operand pins after accept, and count cycles to out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic leak);
        int guard = 0;
        leak = 1'b0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        alu_op   = op;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        operand1 = ~a;
        operand2 = ~b;
        alu_op   = ~op;
        cycles   = 1;
        if (in_ready) leak = 1'b1;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (in_ready) leak = 1'b1;
        end
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_count++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_count++;
        check_count++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_count++;
        check_count++;
        if ({result, zero_flag, div_by_zero} !== 34'h0)
            $display("[TB] FAIL reset_outputs: got %h/%b/%b expected 0/0/0", result, zero_flag, div_by_zero);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops[10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF, 4'hF};
        logic [31:0] a[10]   = '{32'h7FFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000001};
        logic [31:0] b[10]   = '{32'h00000001, 32'd5, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                 32'h00000024, 32'd31, 32'd4, 32'h00000001, 32'hFFFFFFFF};
        logic [31:0] e[10]   = '{32'h80000000, 32'h0, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00,
                                 32'h00000010, 32'h00000001, 32'hF8000000, 32'h1, 32'h0};
        int   cyc;
        logic leak;
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], a[i], b[i], cyc, leak);
            check_count++;
            if (cyc !== 1) $display("[TB] FAIL single_latency[%0d]: got %0d expected 1", i, cyc);
            else pass_count++;
            check_count++;
            if (result !== e[i]) $display("[TB] FAIL single_result[%0d]: got %h expected %h", i, result, e[i]);
            else pass_count++;
            check_count++;
            if ({zero_flag, div_by_zero} !== {e[i] == 32'h0, 1'b0})
                $display("[TB] FAIL single_flags[%0d]: got z=%b dbz=%b expected z=%b dbz=0",
                         i, zero_flag, div_by_zero, e[i] == 32'h0);
            else pass_count++;
            retire();
        end
    endtask

    task automatic test_mul();
        logic [3:0]  ops[5] = '{4'h8, 4'h9, 4'hA, 4'h9, 4'h8};
        logic [31:0] a[5]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
        logic [31:0] b[5]   = '{32'h00000002, 32'h00000002, 32'h00000002, 32'h80000000, 32'h00000010};
        logic [31:0] e[5]   = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'h40000000, 32'h23456780};
        int   cyc;
        logic leak;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], a[i], b[i], cyc, leak);
            check_count++;
            if (cyc !== 33) $display("[TB] FAIL mul_latency[%0d]: got %0d expected 33", i, cyc);
            else pass_count++;
            check_count++;
            if (leak !== 1'b0) $display("[TB] FAIL mul_in_ready_busy[%0d]: got %b expected 0", i, leak);
            else pass_count++;
            check_count++;
            if (result !== e[i]) $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, result, e[i]);
            else pass_count++;
            retire();
        end
    endtask

    task automatic test_divide();
`ifdef ALU_MC_DIVIDER_EN
        logic [3:0]  ops[9] = '{4'hB, 4'hD, 4'hC, 4'hE, 4'hB, 4'hE, 4'hC, 4'hB, 4'hD};
        logic [31:0] a[9]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'd7,
                                32'h80000000, 32'h80000000};
        logic [31:0] b[9]   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[9]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                32'hFFFFFFFF, 32'h80000000, 32'h0};
        int          lat[9] = '{33, 33, 33, 33, 1, 1, 1, 1, 1};
        logic        dbz[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        logic [3:0]  ops[5] = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hB};
        logic [31:0] a[5]   = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd5};
        logic [31:0] b[5]   = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0};
        logic [31:0] e[5]   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        int          lat[5] = '{1, 1, 1, 1, 1};
        logic        dbz[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        int   cyc;
        logic leak;
        for (int i = 0; i < $size(ops); i++) begin
            issue(ops[i], a[i], b[i], cyc, leak);
            check_count++;
            if (cyc !== lat[i]) $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, cyc, lat[i]);
            else pass_count++;
            check_count++;
            if (result !== e[i]) $display("[TB] FAIL div_result[%0d]: got %h expected %h", i, result, e[i]);
            else pass_count++;
            check_count++;
            if ({zero_flag, div_by_zero} !== {e[i] == 32'h0, dbz[i]})
                $display("[TB] FAIL div_flags[%0d]: got z=%b dbz=%b expected z=%b dbz=%b",
                         i, zero_flag, div_by_zero, e[i] == 32'h0, dbz[i]);
            else pass_count++;
            retire();
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        logic leak;
        out_ready = 1'b0;
        issue(4'h0, 32'd2, 32'd3, cyc, leak);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_count++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd5})
                $display("[TB] FAIL hold[%0d]: got v=%b r=%b res=%h expected v=1 r=0 res=00000005",
                         i, out_valid, in_ready, result);
            else pass_count++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        else pass_count++;
    endtask

    task automatic test_reset_mid_mul();
        int   cyc;
        logic leak;
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = 4'h9;
        operand1 = 32'hFFFFFFF0;
        operand2 = 32'h00000003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_count++;
        if ({out_valid, in_ready} !== 2'b00)
            $display("[TB] FAIL mid_mul_busy: got v=%b r=%b expected v=0 r=0", out_valid, in_ready);
        else pass_count++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if ({out_valid, in_ready, result, zero_flag} !== {1'b0, 1'b1, 32'h0, 1'b0})
            $display("[TB] FAIL mid_mul_reset: got v=%b r=%b res=%h z=%b expected v=0 r=1 res=0 z=0",
                     out_valid, in_ready, result, zero_flag);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        issue(4'h0, 32'd2, 32'd3, cyc, leak);
        check_count++;
        if (cyc !== 1 || result !== 32'd5)
            $display("[TB] FAIL post_reset_add: got cyc=%0d res=%h expected cyc=1 res=00000005", cyc, result);
        else pass_count++;
        retire();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'h0;
        operand1  = '0;
        operand2  = '0;
        test_reset();
        test_single_cycle();
        test_mul();
        test_divide();
        test_backpressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
